// File: rtl/uart_rx_ip_pkg.sv
// Shared definitions for the UART receiver IP: register offsets, STATUS bit
// positions, receiver state encoding and divisor constants.
package uart_rx_ip_pkg;

    // Word offsets, decoded from address bits [3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    // STATUS register bit positions
    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DEFAULT_DIV = 260;
    localparam logic [DIV_W-1:0] MIN_DIV = 16'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ip_fifo.sv
// rx_fifo: synchronous receive FIFO.
// Ports: push/wdata write side, pop/rdata read side (rdata = current head),
// full/empty/level status. Push while full is ignored unless a pop happens in
// the same cycle; pop while empty is ignored.
module rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    import uart_rx_ip_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign rdata     = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push_c) wptr <= wptr + AW'(1);
            if (do_pop_c)  rptr <= rptr + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by level
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: 8N1 UART receiver with receive FIFO and a small register bank.
// Ports: clk/rst (async active-high); write bus waddr/wdata/wen/wstrb -> wready;
// read bus raddr/ren -> rdata/rvalid (one cycle latency); i_uart_rx serial in.
// Registers: 0x0 DATA (pop head), 0x4 STATUS, 0x8 BAUD_DIV.
module uart_rx_ip #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = uart_rx_ip_pkg::DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx
);
    import uart_rx_ip_pkg::*;

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    // Synchronizer and edge detect
    logic [1:0] rx_sync;
    logic [1:0] sync_vld;
    logic       rx_s;
    logic       rx_prev;
    logic       fall_c;

    // Receiver state
    rx_state_e        state, state_next;
    logic [DIV_W-1:0] cnt, cnt_next;
    logic [DIV_W-1:0] work_div, div_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             push_c;
    logic             frame_set_c;

    // Registers and FIFO hookup
    logic [DIV_W-1:0] baud_div;
    logic             overrun;
    logic             frame_err;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic [7:0]       fifo_head;
    logic             pop_c;
    logic             overrun_set_c;
    logic             status_wr_c;
    logic [3:0]       level_nib;
    logic [31:0]      status_word;
    logic [DIV_W-1:0] baud_wr_c;
    logic             unused_bits;

    assign rx_s = rx_sync[1];

    // rx_prev only follows the line once the synchronizer holds real samples,
    // so a line held low through reset cannot look like a start edge.
    assign fall_c = sync_vld[1] && rx_prev && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            sync_vld <= 2'b00;
            rx_prev  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], i_uart_rx};
            sync_vld <= {sync_vld[0], 1'b1};
            rx_prev  <= sync_vld[1] ? rx_s : 1'b0;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            work_div <= DIV_W'(DEFAULT_DIV);
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            work_div <= div_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    // Receiver next-state: half-bit start check, then full-bit sampling
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        div_next    = work_div;
        bit_next    = bit_idx;
        shift_next  = shift;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_c) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    div_next   = baud_div;
                end
            end
            S_START: begin
                if (cnt == (work_div >> 1) - DIV_W'(1)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == work_div - DIV_W'(1)) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == work_div - DIV_W'(1)) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        push_c     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_set_c = 1'b1;
                        state_next  = S_BREAK_WAIT;
                    end
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end
            S_BREAK_WAIT: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (shift),
        .pop   (pop_c),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign pop_c         = ren && (raddr[3:2] == OFF_DATA) && !fifo_empty;
    assign overrun_set_c = push_c && fifo_full && !pop_c;
    assign status_wr_c   = wen && (waddr[3:2] == OFF_STATUS) && wstrb[0];

    // Level field is four bits wide; deeper FIFOs saturate it
    assign level_nib = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);

    always_comb begin
        status_word = '0;
        status_word[ST_NOT_EMPTY]               = !fifo_empty;
        status_word[ST_FULL]                    = fifo_full;
        status_word[ST_OVERRUN]                 = overrun;
        status_word[ST_FRAME_ERR]               = frame_err;
        status_word[ST_LEVEL_LSB+3:ST_LEVEL_LSB] = level_nib;
    end

    // Byte-lane merge of a BAUD_DIV write, clamped to the minimum divisor
    always_comb begin
        baud_wr_c = baud_div;
        if (wstrb[0]) baud_wr_c[7:0]  = wdata[7:0];
        if (wstrb[1]) baud_wr_c[15:8] = wdata[15:8];
        if (baud_wr_c < MIN_DIV) baud_wr_c = MIN_DIV;
    end

    // Register bank, sticky flags and bus handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div  <= DIV_W'(DEFAULT_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            wready <= wen;
            rvalid <= ren;
            if (wen && (waddr[3:2] == OFF_BAUD)) baud_div <= baud_wr_c;
            // Set takes priority over a same-cycle W1C
            overrun   <= overrun_set_c ||
                         (overrun && !(status_wr_c && wdata[ST_OVERRUN]));
            frame_err <= frame_set_c ||
                         (frame_err && !(status_wr_c && wdata[ST_FRAME_ERR]));
            if (ren) begin
                case (raddr[3:2])
                    OFF_DATA:   rdata <= fifo_empty ? 32'd0 : 32'(fifo_head);
                    OFF_STATUS: rdata <= status_word;
                    OFF_BAUD:   rdata <= 32'(baud_div);
                    default:    rdata <= 32'd0;
                endcase
            end
        end
    end

    assign unused_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0],
                           wdata[31:16], wstrb[3:2]};

endmodule
